// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU logic-unit driver and anything that needs
// a reference model of the logic unit.
//   - OP_* : 4-bit op codes of the unit's 16-entry encoding
//   - state_t : driver FSM states
//   - logic_eval : reference result of one op (operands zero-extended to MAX_W)
package alu_logic_pkg;

  // Widest operand logic_eval can model; callers cast in and truncate out.
  localparam int unsigned MAX_W = 64;

  localparam logic [3:0] OP_ZERO    = 4'b0000;
  localparam logic [3:0] OP_NOR     = 4'b0001;
  localparam logic [3:0] OP_A_NB    = 4'b0010;
  localparam logic [3:0] OP_NB      = 4'b0011;
  localparam logic [3:0] OP_NA_B    = 4'b0100;
  localparam logic [3:0] OP_NA      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_NAND    = 4'b0111;
  localparam logic [3:0] OP_AND     = 4'b1000;
  localparam logic [3:0] OP_XNOR    = 4'b1001;
  localparam logic [3:0] OP_A       = 4'b1010;
  localparam logic [3:0] OP_A_OR_NB = 4'b1011;
  localparam logic [3:0] OP_B       = 4'b1100;
  localparam logic [3:0] OP_NA_OR_B = 4'b1101;
  localparam logic [3:0] OP_OR      = 4'b1110;
  localparam logic [3:0] OP_ONES    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [MAX_W-1:0] logic_eval(
    input logic [3:0]       op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    logic [MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_ZERO:    r = '0;
      OP_NOR:     r = ~(a | b);
      OP_A_NB:    r = a & ~b;
      OP_NB:      r = ~b;
      OP_NA_B:    r = ~a & b;
      OP_NA:      r = ~a;
      OP_XOR:     r = a ^ b;
      OP_NAND:    r = ~(a & b);
      OP_AND:     r = a & b;
      OP_XNOR:    r = ~(a ^ b);
      OP_A:       r = a;
      OP_A_OR_NB: r = a | ~b;
      OP_B:       r = b;
      OP_NA_OR_B: r = ~a | b;
      OP_OR:      r = a | b;
      OP_ONES:    r = '1;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Clocked ALU logic unit: bitwise function of lhs_in/rhs_in selected by the
// 4-bit operation, registered through LATENCY pipeline stages. Output is
// not reset.
//   clk       : clock
//   operation : op code; result bit i = operation[{rhs_in[i], lhs_in[i]}]
//   lhs_in    : left operand
//   rhs_in    : right operand
//   out       : result, LATENCY edges after the inputs are sampled
module alu_logic_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] lhs_in,
  input  logic [WIDTH-1:0] rhs_in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] pipe [LATENCY];

  // The op code is the truth table of the function, indexed by {b, a}.
  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = operation[{rhs_in[i], lhs_in[i]}];
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= result;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign out = pipe[LATENCY-1];

endmodule

// File: rtl/alu_logic_driver.sv
// Initiator for the ALU logic unit. Accepts one op over req_valid/req_ready,
// drives the unit, waits out its latency, captures its output and returns it
// with zero/negative/mismatch flags over rsp_valid/rsp_ready.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (req_ready registered, IDLE only)
//   req_op, req_a, req_b   : op code and operands
//   logic_op/lhs/rhs       : driven to the unit, held from accept to next accept
//   logic_out              : unit result
//   rsp_valid/rsp_ready    : response handshake
//   rsp_data               : captured logic_out
//   rsp_zero/neg/mismatch  : data==0, data MSB, data differs from reference
module alu_logic_driver
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       logic_op,
  output logic [WIDTH-1:0] logic_lhs,
  output logic [WIDTH-1:0] logic_rhs,
  input  logic [WIDTH-1:0] logic_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_mismatch
);

  localparam int unsigned CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             cnt_done;

  assign accept   = req_valid && req_ready;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_WAIT;
      ST_WAIT: if (cnt_done)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b0;
      logic_op     <= 4'b0000;
      logic_lhs    <= '0;
      logic_rhs    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
      rsp_neg      <= 1'b0;
      rsp_mismatch <= 1'b0;
      cnt          <= '0;
      expected     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            logic_op  <= req_op;
            logic_lhs <= req_a;
            logic_rhs <= req_b;
            expected  <= WIDTH'(logic_eval(req_op, MAX_W'(req_a), MAX_W'(req_b)));
            cnt       <= CW'(LATENCY);
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        // The unit's out changes on edge E0+LATENCY, so it is only safely
        // sampled one edge later: count LATENCY down, capture on the edge
        // that sees zero.
        ST_WAIT: begin
          if (cnt_done) begin
            rsp_data     <= logic_out;
            rsp_zero     <= (logic_out == '0);
            rsp_neg      <= logic_out[WIDTH-1];
            rsp_mismatch <= (logic_out != expected);
            rsp_valid    <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_logic_driver.md
Name: alu_logic_driver

Overview:
Initiator side of the ALU logic-unit interface. It accepts a logic-op request (op code plus two operands) over a valid/ready handshake and drives the unit's operation/lhs_in/rhs_in inputs. It waits out the unit's registered latency, captures the unit's out, and returns the result with zero/negative flags and a self-check mismatch flag over a second valid/ready handshake. It sits between the control path and the clocked logic unit and is the only agent driving that unit.

Parameters:
WIDTH, 8, operand/result width; must match the logic unit.
LATENCY, 1, clock edges from the unit sampling its inputs to its out being updated (>=1).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  driver can accept a request
req_op  input  4  logic op code, unit's 16-entry encoding (0000 zero ... 1111 all-ones)
req_a  input  WIDTH  left operand
req_b  input  WIDTH  right operand
logic_op  output  4  to unit operation
logic_lhs  output  WIDTH  to unit lhs_in
logic_rhs  output  WIDTH  to unit rhs_in
logic_out  input  WIDTH  from unit out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  captured logic_out
rsp_zero  output  1  rsp_data == 0
rsp_neg  output  1  rsp_data[WIDTH-1]
rsp_mismatch  output  1  rsp_data != locally computed expected value

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; req_ready=0; logic_op=4'b0000; logic_lhs=0; logic_rhs=0; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_neg=0; rsp_mismatch=0; wait counter=0; expected register=0.
- req_ready is registered. It goes to 1 on the first rising edge after rst_n deasserts. It is 1 only in IDLE.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req_valid&&req_ready (accept edge E0):
  - register logic_op/lhs/rhs from the request;
  - register the expected result from the shared op function;
  - load the counter with LATENCY; clear req_ready; go to WAIT.
  - req_valid with req_ready=0 is ignored; the request must be held by its source.
- WAIT: the counter decrements each edge. At edge E0+LATENCY+1, logic_out is captured into rsp_data. The same edge registers the flags rsp_zero, rsp_neg and rsp_mismatch, sets rsp_valid=1, and moves to RESP.
  - The extra edge is required because the unit's out updates at E0+LATENCY.
  - logic_* hold stable throughout WAIT and RESP.
- RESP: rsp_valid and all rsp_* hold stable until an edge with rsp_ready=1. On that edge: rsp_valid=0, req_ready=1, go to IDLE.
  - rsp_* data/flags keep their last values after the handshake.
  - rsp_ready high outside RESP has no effect.
- Throughput: one op per LATENCY+3 edges minimum; there is no request/response overlap (req_ready=0 whenever rsp_valid=1).
- Mismatch: rsp_mismatch=1 iff captured logic_out differs from the expected value. It is informational only; the response is still delivered.
- Reset mid-operation (WAIT or RESP):
  - the in-flight op is dropped; all outputs return to reset values;
  - no response is ever emitted for it;
  - logic_out is not reset and is ignored until a new op is accepted.
- Width: all data paths are WIDTH bits; there is no carry or extension. rsp_neg is the MSB of rsp_data.

Decomposition:
- Shared package alu_logic_pkg, containing:
  - 4-bit op code constants for all 16 ops (OP_ZERO, OP_NOR, OP_A_NB, OP_NB, OP_NA_B, OP_NA, OP_XOR, OP_NAND, OP_AND, OP_XNOR, OP_A, OP_A_OR_NB, OP_B, OP_NA_OR_B, OP_OR, OP_ONES);
  - function logic_eval(op, a, b) returning the expected result. The bench scoreboard reuses the same function.
  - FSM state enum.
- No sub-module; the FSM, counter and capture registers live in one module.
- Bench instantiates the driver connected to the real logic unit.

Test Plan:
- AND, a=0xF0, b=0x3C, rsp_ready=1 -> logic_op=1000 from E0. rsp_valid at E0+2 with rsp_data=0x30, zero=0, neg=0, mismatch=0. req_ready=1 one edge later.
- NOR, a=0x00, b=0x00 -> rsp_data=0xFF, neg=1, zero=0. Then XOR, a=0xAA, b=0xAA -> rsp_data=0x00, zero=1. Then ones op -> 0xFF.
- Backpressure: OR 0x0F|0xF0 with rsp_ready low for 5 cycles -> rsp_valid=1 and rsp_data=0xFF stable all 5 cycles. req_valid held high is not accepted. Response completes on the edge with rsp_ready=1.
- Reset mid-WAIT: accept NAND 0xFF,0xFF with LATENCY=3, pull rst_n low one cycle after accept -> all outputs immediately at reset values. No rsp_valid follows. req_ready=1 on the first edge after release.
- Mismatch injection: force logic_out=0x01 during capture of AND 0x00&0x00 -> rsp_data=0x01, rsp_mismatch=1, rsp_valid still asserted.
- Sweep all 16 op codes with a=0xC5, b=0x3A at LATENCY=1 and LATENCY=3 -> every rsp_data equals logic_eval, mismatch=0. rsp_valid at E0+LATENCY+1.
